// File: rtl/alu_mul_seq_if.sv
// Bus bundle between the sequential multiplier, its requester and the shared ALU.
// The multiplier core uses the slave view. The requester and the ALU use the master view.
interface alu_mul_seq_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            ready;
   logic            done;
   logic [XLEN-1:0] prod_hi;
   logic [XLEN-1:0] prod_lo;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic            alu_c;
   logic [2:0]      alu_op;
   logic [3:0]      alu_status;
   logic [XLEN-1:0] alu_result;

   modport slave (
      input  start, op_a, op_b, alu_status, alu_result,
      output ready, done, prod_hi, prod_lo, alu_a, alu_b, alu_c, alu_op
   );

   modport master (
      output start, op_a, op_b, alu_status, alu_result,
      input  ready, done, prod_hi, prod_lo, alu_a, alu_b, alu_c, alu_op
   );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier: the block issues one external ALU ADD per multiplier bit.
// The product is {acc, mplier} after XLEN iterations.
module alu_mul_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_mul_seq_if.slave  bus
);
   localparam logic [2:0] ALU_ADD = 3'b000;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_reg, state_next;
   logic [XLEN-1:0]     acc_reg, mcand_reg, mplier_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [XLEN-1:0]     prod_hi_reg, prod_lo_reg;
   logic [XLEN-1:0]     addend;
   logic [2*XLEN-1:0]   shift_next;
   logic                accept;
   logic                last_iter;
   logic [2:0]          unused_status;

   assign unused_status = {bus.alu_status[3:2], bus.alu_status[0]};

   // The multiplicand is gated by the current multiplier LSB to form the partial product.
   generate
      for (genvar gi = 0; gi < XLEN; gi++) begin : g_addend
         assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
      end
   endgenerate

   // The carry enters the acc MSB. The sum LSB drops into the vacated multiplier MSB.
   assign shift_next = {bus.alu_status[1], bus.alu_result, mplier_reg[XLEN-1:1]};
   assign last_iter  = (cnt_reg == CNT_W'(XLEN - 1));
   assign accept     = (state_reg != RUN) && bus.start;

   always_comb begin
      state_next = state_reg;
      bus.alu_a  = '0;
      bus.alu_b  = '0;
      bus.alu_c  = 1'b0;
      bus.alu_op = ALU_ADD;
      case (state_reg)
         IDLE: if (bus.start) state_next = RUN;
         RUN: begin
            bus.alu_a = acc_reg;
            bus.alu_b = addend;
            if (last_iter) state_next = DONE;
         end
         DONE: state_next = bus.start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         acc_reg     <= '0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         cnt_reg     <= '0;
         prod_hi_reg <= '0;
         prod_lo_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            mcand_reg  <= bus.op_a;
            mplier_reg <= bus.op_b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
         end else if (state_reg == RUN) begin
            acc_reg    <= shift_next[2*XLEN-1:XLEN];
            mplier_reg <= shift_next[XLEN-1:0];
            cnt_reg    <= cnt_reg + 1'b1;
            if (last_iter) begin
               prod_hi_reg <= shift_next[2*XLEN-1:XLEN];
               prod_lo_reg <= shift_next[XLEN-1:0];
            end
         end
      end
   end

   assign bus.ready   = (state_reg != RUN);
   assign bus.done    = (state_reg == DONE);
   assign bus.prod_hi = prod_hi_reg;
   assign bus.prod_lo = prod_lo_reg;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: a behavioural ALU, a table of known products, random products against
// a plain 64-bit multiply, and hand-written multi-cycle corner cases.
module tb_alu_mul_seq;
   localparam int XLEN = 32;
   localparam int LAT  = XLEN + 1;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   alu_mul_seq_if #(.XLEN(XLEN)) ifc ();

   alu_mul_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational ALU model: a + b + c, returning flags {N,Z,C,V}.
   logic [XLEN:0] alu_full;
   always_comb begin
      alu_full       = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b} + {{XLEN{1'b0}}, ifc.alu_c};
      ifc.alu_result = alu_full[XLEN-1:0];
      ifc.alu_status = {alu_full[XLEN-1], alu_full[XLEN-1:0] == '0, alu_full[XLEN], 1'b0};
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one request. The task returns at the negedge after the accept edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.op_a  = a;
      ifc.op_b  = b;
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   // Step until done is seen, counting edges from the accept edge (edge 1).
   // During RUN, the task checks ready, alu_c, alu_op and, if requested, alu_b == 0.
   task automatic wait_done(input int edges_in, input bit zero_b, output int edges);
      int bad_run;
      bad_run = 0;
      edges   = edges_in;
      while (!ifc.done && edges < 200) begin
         if (ifc.ready !== 1'b0 || ifc.alu_c !== 1'b0 || ifc.alu_op !== 3'b000) bad_run++;
         if (zero_b && ifc.alu_b !== '0) bad_run++;
         @(negedge clk);
         edges++;
      end
      chk("run_cycle_signals", 64'(bad_run), 64'd0);
      if (edges >= 200) chk("done_timeout", 64'(edges), 64'(LAT));
   endtask

   task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input bit zero_b);
      int edges;
      issue(a, b);
      wait_done(1, zero_b, edges);
      chk({name, "_latency"}, 64'(edges), 64'(LAT));
      chk({name, "_ready_at_done"}, 64'(ifc.ready), 64'd1);
      chk({name, "_prod"}, {ifc.prod_hi, ifc.prod_lo}, {ehi, elo});
      $display("[TB] %s a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h lat=%0d",
               name, a, b, ifc.prod_hi, ifc.prod_lo, edges);
   endtask

   initial begin
      vec_t vecs [8];
      int edges;
      int done_seen;
      logic [31:0] ra, rb;
      logic [63:0] ref_p;

      tests = 0;
      fails = 0;

      vecs[0] = '{32'd3,         32'd5,         32'h0,        32'd15};
      vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001};
      vecs[2] = '{32'h12345678,  32'h0,         32'h0,        32'h0};
      vecs[3] = '{32'h10000,     32'h10000,     32'h1,        32'h0};
      vecs[4] = '{32'd7,         32'd6,         32'h0,        32'd42};
      vecs[5] = '{32'h1,         32'hFFFFFFFF,  32'h0,        32'hFFFFFFFF};
      vecs[6] = '{32'h80000000,  32'h2,         32'h1,        32'h0};
      vecs[7] = '{32'hFFFF,      32'hFFFF,      32'h0,        32'hFFFE0001};

      // Reset is held with start asserted, so reset must win.
      rst_n     = 1'b0;
      ifc.start = 1'b1;
      ifc.op_a  = 32'hDEAD;
      ifc.op_b  = 32'hBEEF;
      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(ifc.ready), 64'd1);
      chk("reset_done", 64'(ifc.done), 64'd0);
      chk("reset_prod", {ifc.prod_hi, ifc.prod_lo}, 64'd0);
      chk("reset_alu_ops", {ifc.alu_a, ifc.alu_b}, 64'd0);
      ifc.start = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      chk("idle_alu_a", 64'(ifc.alu_a), 64'd0);

      for (int i = 0; i < 8; i++)
         run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   vecs[i].b == 32'h0);

      for (int i = 0; i < 20; i++) begin
         ra    = $urandom;
         rb    = (i % 5 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         ref_p = 64'(ra) * 64'(rb);
         run_check($sformatf("rand%0d", i), ra, rb, ref_p[63:32], ref_p[31:0], rb == 32'h0);
      end

      // A start asserted during RUN with other operands must be ignored.
      issue(32'h00ABCDEF, 32'h00001234);
      edges = 1;
      repeat (4) begin
         ifc.start = 1'b1;
         ifc.op_a  = $urandom;
         ifc.op_b  = $urandom;
         @(negedge clk);
         edges++;
      end
      ifc.start = 1'b0;
      wait_done(edges, 1'b0, edges);
      ref_p = 64'(32'h00ABCDEF) * 64'(32'h00001234);
      chk("midrun_start_latency", 64'(edges), 64'(LAT));
      chk("midrun_start_prod", {ifc.prod_hi, ifc.prod_lo}, ref_p);
      $display("[TB] midrun_start -> hi=0x%08h lo=0x%08h", ifc.prod_hi, ifc.prod_lo);

      // Back-to-back: a start on the done cycle goes straight to RUN.
      issue(32'd3, 32'd5);
      wait_done(1, 1'b0, edges);
      chk("b2b_first_prod", {ifc.prod_hi, ifc.prod_lo}, 64'd15);
      ifc.start = 1'b1;
      ifc.op_a  = 32'h10000;
      ifc.op_b  = 32'h10000;
      @(negedge clk);
      ifc.start = 1'b0;
      chk("b2b_accepted", 64'(ifc.ready), 64'd0);
      chk("b2b_prod_held", {ifc.prod_hi, ifc.prod_lo}, 64'd15);
      wait_done(1, 1'b0, edges);
      chk("b2b_latency", 64'(edges), 64'(LAT));
      chk("b2b_second_prod", {ifc.prod_hi, ifc.prod_lo}, {32'h1, 32'h0});
      $display("[TB] back_to_back -> hi=0x%08h lo=0x%08h lat=%0d", ifc.prod_hi, ifc.prod_lo, edges);
      @(negedge clk);
      chk("done_one_cycle", 64'(ifc.done), 64'd0);

      // Reset during RUN aborts the operation without a done pulse.
      issue(32'hCAFEBABE, 32'h12345);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_ready", 64'(ifc.ready), 64'd1);
      chk("abort_done", 64'(ifc.done), 64'd0);
      chk("abort_prod", {ifc.prod_hi, ifc.prod_lo}, 64'd0);
      rst_n     = 1'b1;
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (ifc.done) done_seen++;
      end
      chk("abort_no_done", 64'(done_seen), 64'd0);
      $display("[TB] reset_abort -> done pulses after abort=%0d", done_seen);
      run_check("after_abort", 32'd7, 32'd6, 32'h0, 32'd42, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
